dht11_ctrl: RTL and testbench

//  DHT11 single-wire protocol controller; sits directly downstream of the 10 us tick generator and is timed only by its tick.
//  On a start request: drives the 18 ms start pulse, detects the sensor response, samples 40 data bits and checks the checksum.

---
 rtl/dht11_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_dht11_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_ctrl.sv
// DHT11 single-wire controller: start pulse, response detect,
// 40-bit capture and checksum, all timed by an external 10 us tick.
module dht11_ctrl #(
  parameter int START_LOW_TICKS  = 1800,
  parameter int WAIT_REL_TICKS   = 3,
  parameter int TIMEOUT_TICKS    = 20,
  parameter int BIT_THRESH_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic       i_dht,
  output logic       o_dht_oe,
  output logic [7:0] o_humid_int,
  output logic [7:0] o_humid_dec,
  output logic [7:0] o_temp_int,
  output logic [7:0] o_temp_dec,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_busy
);

  localparam int CW = $clog2(START_LOW_TICKS + 1);

  localparam logic [CW-1:0] START_END = CW'(START_LOW_TICKS - 1);
  localparam logic [CW-1:0] WAIT_END  = CW'(WAIT_REL_TICKS - 1);
  localparam logic [CW-1:0] TO_END    = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] THRESH    = CW'(BIT_THRESH_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP_LO,
    S_RESP_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CHECK
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0] tick_cnt;
  logic [5:0]    bit_cnt;
  logic [39:0]   shreg;

  logic sync1;
  logic sync2;
  logic sync3;
  logic rise;
  logic fall;

  logic timeout;
  logic shift_en;
  logic load;
  logic set_err;
  logic clr_err;
  logic [7:0] sum;
  logic sum_ok;

  // Line idles high through the external pull-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= i_dht;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;

  assign sum = shreg[39:32] + shreg[31:24]
             + shreg[23:16] + shreg[15:8];
  assign sum_ok = (sum == shreg[7:0]);

  assign timeout = i_tick && (tick_cnt == TO_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Edges are checked before the timeout so an edge wins a shared clock.
  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    load     = 1'b0;
    set_err  = 1'b0;
    clr_err  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          state_n = S_START;
          clr_err = 1'b1;
        end
      end
      S_START: begin
        if (i_tick && tick_cnt == START_END)
          state_n = S_WAIT;
      end
      S_WAIT: begin
        if (i_tick && tick_cnt == WAIT_END)
          state_n = S_RESP_LO;
      end
      S_RESP_LO: begin
        if (rise) begin
          state_n = S_RESP_HI;
        end else if (timeout) begin
          state_n = S_IDLE;
          set_err = 1'b1;
        end
      end
      S_RESP_HI: begin
        if (fall) begin
          state_n = S_DATA_LO;
        end else if (timeout) begin
          state_n = S_IDLE;
          set_err = 1'b1;
        end
      end
      S_DATA_LO: begin
        if (rise) begin
          state_n = S_DATA_HI;
        end else if (timeout) begin
          state_n = S_IDLE;
          set_err = 1'b1;
        end
      end
      S_DATA_HI: begin
        if (fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 6'd39) state_n = S_CHECK;
          else                  state_n = S_DATA_LO;
        end else if (timeout) begin
          state_n = S_IDLE;
          set_err = 1'b1;
        end
      end
      S_CHECK: begin
        state_n = S_IDLE;
        if (sum_ok) load    = 1'b1;
        else        set_err = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (state_n != state || state == S_IDLE) begin
      tick_cnt <= '0;
    end else if (i_tick) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (state == S_IDLE) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 1'b1;
      shreg   <= {shreg[38:0], (tick_cnt >= THRESH)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_dht_oe    <= 1'b0;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
      o_humid_int <= '0;
      o_humid_dec <= '0;
      o_temp_int  <= '0;
      o_temp_dec  <= '0;
    end else begin
      o_dht_oe <= (state_n == S_START);
      o_valid  <= load;
      if (clr_err)      o_err <= 1'b0;
      else if (set_err) o_err <= 1'b1;
      if (load) begin
        o_humid_int <= shreg[39:32];
        o_humid_dec <= shreg[31:24];
        o_temp_int  <= shreg[23:16];
        o_temp_dec  <= shreg[15:8];
      end
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_dht11_ctrl.sv
// Bench for dht11_ctrl: sensor line model plus a queue scoreboard
// checked by an independent monitor on every valid/err event.
module tb_dht11_ctrl;

  localparam int T   = 4;
  localparam int LIM = 30000;

  logic       clk;
  logic       rst;
  logic       i_tick;
  logic       i_start;
  logic       i_dht;
  logic       o_dht_oe;
  logic [7:0] o_humid_int;
  logic [7:0] o_humid_dec;
  logic [7:0] o_temp_int;
  logic [7:0] o_temp_dec;
  logic       o_valid;
  logic       o_err;
  logic       o_busy;

  logic sens;
  int   total;
  int   bad;
  int   n_valid;
  int   tcnt;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  dht11_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (i_tick),
    .i_start     (i_start),
    .i_dht       (i_dht),
    .o_dht_oe    (o_dht_oe),
    .o_humid_int (o_humid_int),
    .o_humid_dec (o_humid_dec),
    .o_temp_int  (o_temp_int),
    .o_temp_dec  (o_temp_dec),
    .o_valid     (o_valid),
    .o_err       (o_err),
    .o_busy      (o_busy)
  );

  // Open-drain line: our pull-down wins over the sensor.
  assign i_dht = o_dht_oe ? 1'b0 : sens;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tcnt   = 0;
    i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt   = (tcnt + 1) % T;
      i_tick = (tcnt == 0);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {o_humid_int, o_humid_dec, o_temp_int, o_temp_dec};
  endfunction

  initial begin
    logic prev_err;
    exp_t e;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid) n_valid++;
      if (o_valid || (o_err && !prev_err)) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: valid=%b err=%b", o_valid, o_err);
        end else begin
          e = sb.pop_front();
          if (o_valid !== !e.is_err || o_err !== e.is_err
              || outs() !== e.data) begin
            bad++;
            $display("FAIL sb_event: got v=%b e=%b d=%h want e=%b d=%h",
                     o_valid, o_err, outs(), e.is_err, e.data);
          end
        end
      end
      prev_err = o_err;
    end
  end

  task automatic pulse_start();
    i_start = 1'b1;
    clks(1);
    i_start = 1'b0;
  endtask

  task automatic sensor(input logic [39:0] fr, input int poke);
    int n;
    n = 0;
    while (!o_dht_oe && n < LIM) begin clks(1); n++; end
    n = 0;
    while (o_dht_oe && n < LIM) begin clks(1); n++; end
    if (n >= LIM) begin
      total++; bad++;
      $display("FAIL sensor_wait: oe stuck high");
    end
    clks(2*T);
    sens = 1'b0; clks(8*T);
    sens = 1'b1; clks(8*T);
    for (int i = 39; i >= 0; i--) begin
      sens = 1'b0; clks(5*T);
      sens = 1'b1;
      if (39 - i == poke) begin
        clks(2);
        pulse_start();
        clks(fr[i] ? 7*T-3 : 2*T-3);
      end else begin
        clks(fr[i] ? 7*T : 2*T);
      end
    end
    sens = 1'b0; clks(5*T);
    sens = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < LIM) begin clks(1); n++; end
    if (n >= LIM) begin
      total++; bad++;
      $display("FAIL wait_idle: busy stuck");
    end
  endtask

  task automatic push(input logic is_err, input logic [31:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    sb.push_back(e);
  endtask

  localparam logic [39:0] GOOD = 40'h37_00_1A_00_51;
  localparam logic [39:0] BADC = 40'h37_00_1A_00_52;
  localparam logic [31:0] GD   = 32'h37_00_1A_00;

  initial begin
    int tk;
    int n;
    int v0;
    total   = 0;
    bad     = 0;
    n_valid = 0;
    sens    = 1'b1;
    i_start = 1'b0;
    rst     = 1'b1;
    clks(5);
    @(negedge clk);
    check("rst_oe",    32'(o_dht_oe), 0);
    check("rst_data",  outs(), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_err",   32'(o_err), 0);
    check("rst_busy",  32'(o_busy), 0);
    clks(1);
    rst = 1'b0;
    clks(3);

    // start pulse width, then good frame
    push(1'b0, GD);
    v0 = n_valid;
    tk = 0;
    fork
      begin pulse_start(); sensor(GOOD, -1); end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!o_dht_oe && n < LIM);
        while (o_dht_oe && n < LIM) begin
          if (i_tick) tk++;
          @(negedge clk); n++;
        end
        check("start_ticks", tk, 1800);
        check("wait_busy", 32'(o_busy), 1);
      end
    join
    wait_idle();
    clks(2);
    check("good_valid_cnt", n_valid - v0, 1);
    check("good_hum", 32'(o_humid_int), 55);
    check("good_tmp", 32'(o_temp_int), 26);
    check("good_err", 32'(o_err), 0);
    check("good_busy", 32'(o_busy), 0);

    // bad checksum keeps old data
    push(1'b1, GD);
    v0 = n_valid;
    pulse_start();
    sensor(BADC, -1);
    wait_idle();
    clks(2);
    check("badc_err", 32'(o_err), 1);
    check("badc_novalid", n_valid - v0, 0);
    check("badc_hold", outs(), GD);

    // silent sensor: timeout 3 + 20 ticks after release
    push(1'b1, GD);
    pulse_start();
    n = 0;
    while (!o_dht_oe && n < LIM) begin @(negedge clk); n++; end
    while (o_dht_oe && n < LIM) begin @(negedge clk); n++; end
    tk = 0;
    while (!o_err && n < LIM) begin
      if (i_tick) tk++;
      @(negedge clk); n++;
    end
    check("to_ticks", tk, 23);
    check("to_busy", 32'(o_busy), 0);
    check("to_oe", 32'(o_dht_oe), 0);

    // start request during bit 10 is ignored
    push(1'b0, GD);
    v0 = n_valid;
    clks(T);
    pulse_start();
    sensor(GOOD, 10);
    wait_idle();
    clks(50);
    check("poke_valid_cnt", n_valid - v0, 1);
    check("poke_norestart", 32'(o_busy), 0);
    check("poke_err", 32'(o_err), 0);

    // reset in the middle of the start pulse
    pulse_start();
    clks(100*T);
    check("mid_oe", 32'(o_dht_oe), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_oe", 32'(o_dht_oe), 0);
    check("rst_mid_data", outs(), 0);
    check("rst_mid_busy", 32'(o_busy), 0);
    clks(2);
    rst = 1'b0;
    clks(2);
    push(1'b0, GD);
    pulse_start();
    sensor(GOOD, -1);
    wait_idle();
    clks(2);
    check("restart_data", outs(), GD);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
